spatz_tcdm_remap_xbar: RTL and testbench

//   Parametrised TCDM request crossbar (NumInp masters -> NumOut SRAM banks) with runtime-selectable

---
 rtl/spatz_tcdm_remap_xbar_if.sv | 46 ++++
 rtl/spatz_tcdm_remap_xbar.sv | 162 ++++++++++++++++
 tb/tb_spatz_tcdm_remap_xbar.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spatz_tcdm_remap_xbar_if.sv
// Bundle of the configuration, request/response and bank-side signals of the TCDM remap crossbar.
// The crossbar takes the slave view; the surrounding cluster (or a bench) takes the master view.
interface spatz_tcdm_remap_xbar_if #(
    parameter int unsigned NumInp       = 4,
    parameter int unsigned NumOut       = 16,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned DataWidth    = 64
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                                   cfg_valid;
    logic                                   cfg_mode;
    logic                                   cfg_ready;
    logic                                   mode;
    logic [NumInp-1:0]                      req_valid;
    logic [NumInp-1:0]                      req_ready;
    logic [NumInp-1:0][AddrWidth-1:0]       req_addr;
    logic [NumInp-1:0]                      req_write;
    logic [NumInp-1:0][DataWidth-1:0]       req_wdata;
    logic [NumInp-1:0][StrbWidth-1:0]       req_strb;
    logic [NumInp-1:0]                      rsp_valid;
    logic [NumInp-1:0][DataWidth-1:0]       rsp_rdata;
    logic [NumOut-1:0]                      mem_req;
    logic [NumOut-1:0]                      mem_gnt;
    logic [NumOut-1:0][MemAddrWidth-1:0]    mem_addr;
    logic [NumOut-1:0]                      mem_we;
    logic [NumOut-1:0][DataWidth-1:0]       mem_wdata;
    logic [NumOut-1:0][StrbWidth-1:0]       mem_strb;
    logic [NumOut-1:0][DataWidth-1:0]       mem_rdata;
    logic [31:0]                            conflict_cnt;

    modport slave (
        input  cfg_valid, cfg_mode, req_valid, req_addr, req_write, req_wdata, req_strb,
               mem_gnt, mem_rdata,
        output cfg_ready, mode, req_ready, rsp_valid, rsp_rdata,
               mem_req, mem_addr, mem_we, mem_wdata, mem_strb, conflict_cnt
    );

    modport master (
        output cfg_valid, cfg_mode, req_valid, req_addr, req_write, req_wdata, req_strb,
               mem_gnt, mem_rdata,
        input  cfg_ready, mode, req_ready, rsp_valid, rsp_rdata,
               mem_req, mem_addr, mem_we, mem_wdata, mem_strb, conflict_cnt
    );
endinterface

// File: rtl/spatz_tcdm_remap_xbar.sv
// TCDM request crossbar with runtime interleaved/partitioned bank mapping, per-bank round-robin
// arbitration, fixed-latency response return and a drain-before-switch mode change.
module spatz_tcdm_remap_lane #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned BO           = 3,
    parameter int unsigned SW           = 4,
    parameter int unsigned PW           = 1,
    parameter int unsigned PartBit      = 14
) (
    input  logic                    mode,
    input  logic [AddrWidth-1:0]    addr,
    output logic [SW-1:0]           bank,
    output logic [MemAddrWidth-1:0] row
);
    localparam int unsigned PB  = SW - PW;
    localparam int unsigned LoW = PartBit - BO - PB;

    logic [AddrWidth-1:0] lo_mask, pb_mask, row_il, row_pt;
    logic [SW-1:0]        bank_il, bank_pt;

    always_comb begin
        lo_mask = (AddrWidth'(1) << LoW) - AddrWidth'(1);
        pb_mask = (AddrWidth'(1) << PB) - AddrWidth'(1);
        bank_il = SW'(addr >> BO);
        row_il  = addr >> (BO + SW);
        // partition index lands in the top PW bank bits; the field itself is cut out of the row
        bank_pt = SW'((addr >> PartBit) << PB) | SW'((addr >> BO) & pb_mask);
        row_pt  = ((addr >> (PartBit + PW)) << LoW) | ((addr >> (BO + PB)) & lo_mask);
        bank    = mode ? bank_pt : bank_il;
        row     = MemAddrWidth'(mode ? row_pt : row_il);
    end
endmodule

module spatz_tcdm_remap_xbar #(
    parameter int unsigned NumInp       = 4,
    parameter int unsigned NumOut       = 16,
    parameter int unsigned NumPart      = 2,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned MemAddrWidth = 10,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned PartBit      = 14,
    parameter int unsigned MemLatency   = 1,
    parameter bit          ResetMode    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    spatz_tcdm_remap_xbar_if.slave bus
);
    localparam int unsigned BO    = $clog2(DataWidth / 8);
    localparam int unsigned SW    = $clog2(NumOut);
    localparam int unsigned PW    = (NumPart > 1) ? $clog2(NumPart) : 0;
    localparam int unsigned IW    = (NumInp > 1) ? $clog2(NumInp) : 1;
    localparam int unsigned PipeW = MemLatency * SW;

    typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_e;

    state_e                                   state_q, state_d;
    logic                                     mode_q, run, drained, stall;
    logic [NumInp-1:0][SW-1:0]                bank;
    logic [NumInp-1:0][MemAddrWidth-1:0]      row;
    logic [NumOut-1:0][IW-1:0]                rr_q, win;
    logic [NumOut-1:0]                        hit, mem_req;
    logic [NumInp-1:0]                        gnt;
    logic [NumInp-1:0][MemLatency-1:0]        vld_pipe;
    logic [NumInp-1:0][MemLatency-1:0][SW-1:0] bank_pipe;
    logic [31:0]                              cnt_q;
    int                                       idx;

    for (genvar i = 0; i < NumInp; i++) begin : g_lane
        spatz_tcdm_remap_lane #(
            .AddrWidth(AddrWidth), .MemAddrWidth(MemAddrWidth),
            .BO(BO), .SW(SW), .PW(PW), .PartBit(PartBit)
        ) u_lane (
            .mode(mode_q), .addr(bus.req_addr[i]), .bank(bank[i]), .row(row[i])
        );
    end

    // a pending mode change blocks new grants in the very cycle it is raised
    assign run     = (state_q == RUN) && !bus.cfg_valid;
    assign drained = ~|vld_pipe;

    always_comb begin
        hit = '0;
        win = '0;
        idx = 0;
        for (int b = 0; b < NumOut; b++) begin
            for (int k = 0; k < NumInp; k++) begin
                idx = (int'(rr_q[b]) + k) % NumInp;
                if (!hit[b] && bus.req_valid[idx] && bank[idx] == SW'(b)) begin
                    hit[b] = 1'b1;
                    win[b] = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NumInp; i++)
            gnt[i] = run && bus.req_valid[i] && hit[bank[i]] && (win[bank[i]] == IW'(i))
                     && bus.mem_gnt[bank[i]];
        mem_req = '0;
        for (int b = 0; b < NumOut; b++) begin
            mem_req[b]       = run && hit[b];
            bus.mem_addr[b]  = row[win[b]];
            bus.mem_we[b]    = hit[b] && bus.req_write[win[b]];
            bus.mem_wdata[b] = bus.req_wdata[win[b]];
            bus.mem_strb[b]  = bus.req_strb[win[b]];
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.req_ready = gnt;
    assign stall         = (state_q == RUN) && |(bus.req_valid & ~gnt);

    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            bus.rsp_valid[i] = vld_pipe[i][MemLatency-1];
            bus.rsp_rdata[i] = bus.mem_rdata[bank_pipe[i][MemLatency-1]];
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.cfg_ready = 1'b0;
        unique case (state_q)
            RUN:     if (bus.cfg_valid) state_d = DRAIN;
            DRAIN:   if (drained) state_d = SWITCH;
            SWITCH: begin
                bus.cfg_ready = 1'b1;
                state_d       = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            mode_q    <= ResetMode;
            rr_q      <= '0;
            vld_pipe  <= '0;
            bank_pipe <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SWITCH) mode_q <= bus.cfg_mode;
            for (int b = 0; b < NumOut; b++)
                if (mem_req[b] && bus.mem_gnt[b])
                    rr_q[b] <= (win[b] == IW'(NumInp - 1)) ? '0 : win[b] + IW'(1);
            for (int i = 0; i < NumInp; i++) begin
                vld_pipe[i]  <= MemLatency'({vld_pipe[i], gnt[i]});
                bank_pipe[i] <= PipeW'({bank_pipe[i], bank[i]});
            end
            if (stall && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.mode         = mode_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_spatz_tcdm_remap_xbar.sv
// Directed bench for the TCDM remap crossbar: mapping in both modes, arbitration rotation,
// bank stalls, drain-before-switch and reset with traffic in flight.
module tb_spatz_tcdm_remap_xbar;
    localparam int NI = 4, NO = 16, AW = 32, MW = 10, DW = 64, ML = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0, failures = 0;
    logic [3:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

    always #5 clk = ~clk;

    spatz_tcdm_remap_xbar_if #(
        .NumInp(NI), .NumOut(NO), .AddrWidth(AW), .MemAddrWidth(MW), .DataWidth(DW)
    ) bus ();

    spatz_tcdm_remap_xbar #(
        .NumInp(NI), .NumOut(NO), .NumPart(2), .AddrWidth(AW), .MemAddrWidth(MW),
        .DataWidth(DW), .PartBit(14), .MemLatency(ML), .ResetMode(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int b);
        return 64'hDA7A_0000_0000_0000 | 64'(b);
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_write = '0;
    endtask

    task automatic rq(input int i, input logic [31:0] a);
        bus.req_valid[i] = 1'b1;
        bus.req_addr[i]  = a;
        bus.req_write[i] = 1'b0;
        bus.req_wdata[i] = '0;
        bus.req_strb[i]  = 8'hFF;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_mode  = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.mem_gnt   = '1;
        for (int b = 0; b < NO; b++) bus.mem_rdata[b] = pat(b);
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mode", bus.mode, 0);
        chk("rst_rsp", bus.rsp_valid, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_cnt", bus.conflict_cnt, 0);
        chk("rst_mem_req", bus.mem_req, 0);

        // interleaved reads to four consecutive words
        cyc; rq(0, 'h00); rq(1, 'h08); rq(2, 'h10); rq(3, 'h18);
        @(negedge clk);
        chk("il_ready", bus.req_ready, 4'hF);
        chk("il_mem_req", bus.mem_req, 16'h000F);
        chk("il_row2", bus.mem_addr[2], 0);
        cyc; idle();
        @(negedge clk); chk("il_rsp_l1", bus.rsp_valid, 0);
        cyc; @(negedge clk); chk("il_rsp_l2", bus.rsp_valid, 0);
        cyc; @(negedge clk);
        chk("il_rsp", bus.rsp_valid, 4'hF);
        chk("il_rdata0", bus.rsp_rdata[0], pat(0));
        chk("il_rdata3", bus.rsp_rdata[3], pat(3));
        cyc; @(negedge clk); chk("il_rsp_end", bus.rsp_valid, 0);

        // interleaved write: 0x1A8 -> bank 5 row 3
        cyc; bus.req_valid[3] = 1'b1; bus.req_addr[3] = 'h1A8; bus.req_write[3] = 1'b1;
        bus.req_wdata[3] = 64'h1234_5678_9ABC_DEF0; bus.req_strb[3] = 8'hF0;
        @(negedge clk);
        chk("wr_ready", bus.req_ready, 4'b1000);
        chk("wr_mem_req", bus.mem_req, 16'h0020);
        chk("wr_row", bus.mem_addr[5], 3);
        chk("wr_we", bus.mem_we[5], 1);
        chk("wr_wdata", bus.mem_wdata[5], 64'h1234_5678_9ABC_DEF0);
        chk("wr_strb", bus.mem_strb[5], 8'hF0);
        cyc; idle(); cyc(2);
        @(negedge clk); chk("wr_rsp", bus.rsp_valid, 4'b1000);

        // mode change to partitioned with reads in flight
        cyc; rq(0, 'h00); rq(1, 'h08); rq(2, 'h10); rq(3, 'h18);
        @(negedge clk); chk("sw_issue", bus.req_ready, 4'hF);
        cyc; idle(); bus.cfg_valid = 1'b1; bus.cfg_mode = 1'b1; rq(0, 'h40);
        @(negedge clk);
        chk("sw_block_ready", bus.req_ready, 0);
        chk("sw_block_mem", bus.mem_req, 0);
        chk("sw_cfg_ready0", bus.cfg_ready, 0);
        cyc; idle();
        @(negedge clk); chk("sw_cfg_ready1", bus.cfg_ready, 0);
        cyc; @(negedge clk);
        chk("sw_rsp", bus.rsp_valid, 4'hF);
        chk("sw_cfg_ready2", bus.cfg_ready, 0);
        cyc; @(negedge clk); chk("sw_cfg_ready3", bus.cfg_ready, 0);
        cyc; @(negedge clk);
        chk("sw_cfg_ready", bus.cfg_ready, 1);
        chk("sw_mode_old", bus.mode, 0);
        cyc; bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("sw_mode_new", bus.mode, 1);
        chk("sw_cfg_ready_end", bus.cfg_ready, 0);
        chk("sw_cnt", bus.conflict_cnt, 1);

        // partitioned mapping
        cyc; rq(0, 'h0008); rq(1, 'h4008); rq(2, 'h8050);
        @(negedge clk);
        chk("pt_mem_req", bus.mem_req, 16'h0206);
        chk("pt_ready", bus.req_ready, 4'b0111);
        chk("pt_row1", bus.mem_addr[1], 0);
        chk("pt_row9", bus.mem_addr[9], 0);
        chk("pt_row2", bus.mem_addr[2], 10'h101);
        cyc; idle(); cyc(2);
        @(negedge clk);
        chk("pt_rsp", bus.rsp_valid, 4'b0111);
        chk("pt_rdata1", bus.rsp_rdata[1], pat(9));

        // three inputs contending for bank 5
        cyc; rq(0, 'h28); rq(1, 'h28); rq(2, 'h28);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_%0d", k), bus.req_ready, rr_exp[k]);
            cyc;
        end
        idle();
        @(negedge clk); chk("rr_cnt", bus.conflict_cnt, 5);
        cyc(4);

        // bank 3 withholds its grant for four cycles
        cyc; bus.mem_gnt[3] = 1'b0; rq(1, 'h18);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("st_ready_%0d", k), bus.req_ready, 0);
            chk($sformatf("st_req_%0d", k), bus.mem_req, 16'h0008);
            chk($sformatf("st_rsp_%0d", k), bus.rsp_valid, 0);
            cyc;
        end
        bus.mem_gnt[3] = 1'b1;
        @(negedge clk); chk("st_release", bus.req_ready, 4'b0010);
        cyc; idle(); cyc(2);
        @(negedge clk);
        chk("st_rsp", bus.rsp_valid, 4'b0010);
        chk("st_cnt", bus.conflict_cnt, 9);

        // reset with a read in flight
        cyc; rq(0, 'h0008);
        @(negedge clk); chk("rs_issue", bus.req_ready, 4'b0001);
        cyc; idle(); rst = 1'b1;
        cyc; rst = 1'b0;
        @(negedge clk);
        chk("rs_rsp", bus.rsp_valid, 0);
        chk("rs_mode", bus.mode, 0);
        chk("rs_cnt", bus.conflict_cnt, 0);
        cyc; @(negedge clk); chk("rs_dropped", bus.rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
